// File: rtl/freq_detect.sv
// Peak-bin detector: after each FFT frame, scans channel-1 RAM for the largest |X|^2 in [BIN_LO, BIN_HI].
// Optional: define FREQDET_THRESH_EN to drop frames whose peak power is below MIN_PWR.
module freq_detect #(
   parameter int unsigned BIN_LO  = 1,
   parameter int unsigned BIN_HI  = 511,
   parameter int unsigned RAM_LAT = 2,
   parameter logic [27:0] MIN_PWR = 28'd4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fftdone,
   input  logic [27:0] ramq1,
   output logic [9:0]  rdaddr1,
   output logic [9:0]  maxbin,
   output logic [27:0] maxpwr,
   output logic        detectdone,
   output logic        busy,
   output logic        overrun
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, COMPLETE} state_t;

   localparam logic [9:0] LO         = 10'(BIN_LO);
   localparam logic [9:0] HI         = 10'(BIN_HI);
   localparam logic [2:0] DRAIN_LAST = 3'(RAM_LAT - 1);

   state_t             state, state_next;
   logic [RAM_LAT-1:0] tag_vld;
   logic [9:0]         tag_bin [RAM_LAT];
   logic [2:0]         drain_cnt;
   logic [27:0]        run_pwr, cand_pwr;
   logic [9:0]         run_bin, cand_bin;
   logic signed [13:0] re, im;
   logic [27:0]        re_sq, im_sq, pwr;
   logic               pass;

   // Each square is at most 2^26, so the 28-bit sum cannot overflow.
   assign re    = ramq1[27:14];
   assign im    = ramq1[13:0];
   assign re_sq = re * re;
   assign im_sq = im * im;
   assign pwr   = re_sq + im_sq;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cand_pwr = run_pwr;
      cand_bin = run_bin;
      if (tag_vld[RAM_LAT-1] && (pwr > run_pwr)) begin
         cand_pwr = pwr;
         cand_bin = tag_bin[RAM_LAT-1];
      end
   end

`ifdef FREQDET_THRESH_EN
   assign pass = (cand_pwr >= MIN_PWR);
`else
   assign pass = 1'b1;
`endif

   assign busy       = (state == SCAN) || (state == DRAIN);
   assign detectdone = (state == COMPLETE);

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE, COMPLETE: if (fftdone) state_next = SCAN;
         SCAN:           if (rdaddr1 == HI) state_next = DRAIN;
         DRAIN:          if (drain_cnt == DRAIN_LAST) state_next = pass ? COMPLETE : IDLE;
         default:        state_next = IDLE;
      endcase
   end

   // NOTE: the tag pipeline is reset so a mid-scan reset cannot leak stale valids into the next frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdaddr1   <= '0;
         maxbin    <= '0;
         maxpwr    <= '0;
         overrun   <= 1'b0;
         drain_cnt <= '0;
         run_pwr   <= '0;
         run_bin   <= '0;
         tag_vld   <= '0;
         for (int i = 0; i < RAM_LAT; i++) tag_bin[i] <= '0;
      end else begin
         if (fftdone && busy) overrun <= 1'b1;

         tag_vld[0] <= (state == SCAN);
         tag_bin[0] <= rdaddr1;
         for (int i = 1; i < RAM_LAT; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_bin[i] <= tag_bin[i-1];
         end

         unique case (state)
            IDLE, COMPLETE: begin
               if (fftdone) begin
                  rdaddr1   <= LO;
                  run_pwr   <= '0;
                  run_bin   <= LO;
                  drain_cnt <= '0;
               end
            end
            SCAN: begin
               run_pwr <= cand_pwr;
               run_bin <= cand_bin;
               if (rdaddr1 != HI) rdaddr1 <= rdaddr1 + 10'd1;
            end
            DRAIN: begin
               run_pwr   <= cand_pwr;
               run_bin   <= cand_bin;
               drain_cnt <= drain_cnt + 3'd1;
               // Last sample is compared this cycle; publish it directly from the compare result.
               if (drain_cnt == DRAIN_LAST) begin
                  if (pass) begin
                     maxbin  <= cand_bin;
                     maxpwr  <= cand_pwr;
                     rdaddr1 <= cand_bin;
                  end else begin
                     rdaddr1 <= maxbin;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_freq_detect.sv
// Self-checking bench for freq_detect: directed corner frames plus random frames against an argmax model.
// Honours FREQDET_THRESH_EN when it is defined for the whole build.
module tb_freq_detect;

   localparam int unsigned BIN_LO  = 1;
   localparam int unsigned BIN_HI  = 511;
   localparam int unsigned RAM_LAT = 2;
   localparam logic [27:0] MIN_PWR = 28'd4096;
   localparam int          LAT     = (BIN_HI - BIN_LO + 1) + RAM_LAT + 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fftdone = 1'b0;
   logic [27:0] ramq1 = '0;
   logic [9:0]  rdaddr1, maxbin;
   logic [27:0] maxpwr;
   logic        detectdone, busy, overrun;

   logic [27:0] ram [1024];
   logic [27:0] q_d1 = '0;

   int n_checks = 0;
   int n_fail   = 0;
   int m_bin    = 0;
   int m_pwr    = 0;

   freq_detect #(
      .BIN_LO(BIN_LO), .BIN_HI(BIN_HI), .RAM_LAT(RAM_LAT), .MIN_PWR(MIN_PWR)
   ) dut (
      .clk(clk), .reset(reset), .fftdone(fftdone), .ramq1(ramq1),
      .rdaddr1(rdaddr1), .maxbin(maxbin), .maxpwr(maxpwr),
      .detectdone(detectdone), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Two-cycle read latency RAM: address in cycle c, data in cycle c+2.
   always @(posedge clk) begin
      q_d1  <= ram[rdaddr1];
      ramq1 <= q_d1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [27:0] pack(input int re, input int im);
      return {14'(re), 14'(im)};
   endfunction

   function automatic int pwr_of(input logic [27:0] w);
      int re, im;
      re = int'($signed(w[27:14]));
      im = int'($signed(w[13:0]));
      return re * re + im * im;
   endfunction

   task automatic clear_ram();
      for (int b = 0; b < 1024; b++) ram[b] = '0;
   endtask

   task automatic fill_random(input int span);
      for (int b = 0; b < 1024; b++)
         ram[b] = pack(int'($urandom_range(0, 2 * span)) - span, int'($urandom_range(0, 2 * span)) - span);
   endtask

   // Pulses fftdone in cycle 0; returns just after the edge that starts cycle 1.
   task automatic start_frame();
      @(negedge clk);
      fftdone = 1'b1;
      @(posedge clk);
      #1;
      fftdone = 1'b0;
   endtask

   // Runs one frame and checks it against the model; repulse_at > 0 re-pulses fftdone in that scan cycle.
   task automatic run_frame(input string name, input int repulse_at);
      int best_pwr, best_bin, cyc;
      bit pass;
      best_pwr = 0;
      for (int b = BIN_LO; b <= BIN_HI; b++)
         if (pwr_of(ram[b]) > best_pwr) best_pwr = pwr_of(ram[b]);
      best_bin = -1;
      for (int b = BIN_LO; b <= BIN_HI; b++)
         if (best_bin < 0 && pwr_of(ram[b]) == best_pwr) best_bin = b;
`ifdef FREQDET_THRESH_EN
      pass = (best_pwr >= int'(MIN_PWR));
`else
      pass = 1'b1;
`endif
      start_frame();
      check({name, "_c1_busy"}, busy, 1);
      check({name, "_c1_done_low"}, detectdone, 0);
      check({name, "_c1_addr"}, rdaddr1, BIN_LO);
      check({name, "_c1_maxbin_held"}, maxbin, m_bin);
      cyc = 1;
      if (pass) begin
         while (!detectdone && cyc < LAT + 50) begin
            @(posedge clk);
            #1;
            cyc++;
            fftdone = (cyc == repulse_at);
         end
         fftdone = 1'b0;
         m_bin = best_bin;
         m_pwr = best_pwr;
         check({name, "_latency"}, cyc, LAT);
         check({name, "_maxbin"}, maxbin, m_bin);
         check({name, "_maxpwr"}, maxpwr, m_pwr);
         check({name, "_rdaddr"}, rdaddr1, m_bin);
         check({name, "_busy_low"}, busy, 0);
         repeat (4) @(posedge clk);
         #1;
         check({name, "_hold_done"}, detectdone, 1);
         check({name, "_hold_addr"}, rdaddr1, m_bin);
      end else begin
         repeat (LAT + 2) @(posedge clk);
         #1;
         check({name, "_floor_done_low"}, detectdone, 0);
         check({name, "_floor_idle"}, busy, 0);
         check({name, "_floor_maxbin"}, maxbin, m_bin);
         check({name, "_floor_maxpwr"}, maxpwr, m_pwr);
         check({name, "_floor_rdaddr"}, rdaddr1, m_bin);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_ram();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdaddr", rdaddr1, 0);
      check("rst_maxbin", maxbin, 0);
      check("rst_maxpwr", maxpwr, 0);
      check("rst_done", detectdone, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      reset = 1'b0;

      // Single peak at bin 100.
      clear_ram();
      ram[100] = pack(1000, -1000);
      run_frame("single", 0);
      check("single_pwr_const", maxpwr, 2000000);
      check("single_overrun", overrun, 0);

      // Equal peaks: the lower bin wins.
      clear_ram();
      ram[50]  = pack(300, 400);
      ram[200] = pack(300, 400);
      run_frame("tie", 0);
      check("tie_bin_const", maxbin, 50);
      check("tie_overrun", overrun, 0);

      // DC excluded, bin above BIN_HI excluded, full-scale negative corner.
      clear_ram();
      ram[0]   = pack(8191, 8191);
      ram[7]   = pack(-8192, -8192);
      ram[512] = pack(8191, 8191);
      run_frame("corner", 0);
      check("corner_pwr_const", maxpwr, 134217728);

      // Peak on the last searched bin.
      clear_ram();
      ram[511] = pack(90, -90);
      run_frame("edge_hi", 0);

      // All-zero frame.
      clear_ram();
      run_frame("zero", 0);

      // fftdone during a scan: ignored, but flagged.
      clear_ram();
      ram[100] = pack(1000, -1000);
      run_frame("overrun", 200);
      check("overrun_set", overrun, 1);
      clear_ram();
      ram[321] = pack(-2000, 77);
      run_frame("after_overrun", 0);
      check("overrun_sticky", overrun, 1);

      // Reset mid-scan.
      clear_ram();
      ram[100] = pack(1000, -1000);
      start_frame();
      repeat (299) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_rdaddr", rdaddr1, 0);
      check("midrst_maxbin", maxbin, 0);
      check("midrst_maxpwr", maxpwr, 0);
      check("midrst_done", detectdone, 0);
      check("midrst_busy", busy, 0);
      check("midrst_overrun", overrun, 0);
      reset = 1'b0;
      m_bin = 0;
      m_pwr = 0;
      run_frame("post_rst", 0);

      // Random frames: wide range, then narrow range to provoke ties.
      for (int k = 0; k < 2; k++) begin
         fill_random(8191);
         run_frame("rand_wide", 0);
      end
      for (int k = 0; k < 2; k++) begin
         fill_random(2);
         run_frame("rand_narrow", 0);
      end

`ifdef FREQDET_THRESH_EN
      // Peak just below the floor is dropped, exactly at the floor completes.
      clear_ram();
      ram[9] = pack(40, 40);
      run_frame("floor_below", 0);
      check("floor_below_idle", detectdone, 0);
      clear_ram();
      ram[9] = pack(64, 0);
      run_frame("floor_equal", 0);
      check("floor_equal_bin", maxbin, 9);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
